// File: rtl/weight_programmer.sv
// Streams N*N weight words into the matrix write bus, one per (s,d) pair,
// with optional per-pair readback compare and mismatch statistics.
`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'hA5
`endif

module weight_programmer #(
  parameter int unsigned N         = 8,
  parameter logic [7:0]  ADDR_MASK = `WEIGHT_ADDR_MASK
) (
  input  logic        clk,
  input  logic        axi_rst,
  input  logic        start,
  input  logic        verify_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        wready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_count,
  output logic [31:0] err_addr
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [10:0] LAST = 11'(N - 1);

  state_t      state, state_nxt;
  logic [10:0] s, d;
  logic        verify;
  logic        err_seen;
  logic        advance;
  logic        last_pair;
  logic [31:0] pair_addr;

  assign pair_addr = {ADDR_MASK, d, s, 2'b00};
  assign last_pair = (s == LAST) && (d == LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wready    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        wready = 1'b1;
        if (verify) begin
          state_nxt = READ;
        end else begin
          advance   = 1'b1;
          state_nxt = last_pair ? DONE : FETCH;
        end
      end
      READ:  state_nxt = CHECK;
      CHECK: begin
        advance   = 1'b1;
        state_nxt = last_pair ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state     <= IDLE;
      s         <= '0;
      d         <= '0;
      verify    <= 1'b0;
      err_seen  <= 1'b0;
      wr_addr   <= '0;
      wdata     <= '0;
      rd_addr   <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          err_count <= '0;
          err_addr  <= '0;
          err_seen  <= 1'b0;
          verify    <= verify_en;
          s         <= '0;
          d         <= '0;
        end
        FETCH: if (in_valid) begin
          wdata   <= in_data;
          wr_addr <= pair_addr;
        end
        WRITE: if (verify) rd_addr <= pair_addr;
        CHECK: if (rdata != wdata) begin
          if (err_count != '1) err_count <= err_count + 16'd1;
          // Separate first-mismatch flag keeps err_addr correct even once the count saturates
          if (!err_seen) begin
            err_seen <= 1'b1;
            err_addr <= pair_addr;
          end
        end
        default: ;
      endcase
      if (advance && !last_pair) begin
        if (s == LAST) begin
          s <= '0;
          d <= d + 11'd1;
        end else begin
          s <= s + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_programmer.sv
// Bench for weight_programmer: timing/scoreboard model of the sweep checked every
// cycle, plus directed sweeps pinned with hand-computed literal expectations.
module tb_weight_programmer;
  localparam int unsigned N    = 2;
  localparam logic [7:0]  MASK = 8'hA5;

  logic        clk = 1'b0;
  logic        axi_rst, start, verify_en, in_valid, in_ready, wready, busy, done;
  logic [31:0] in_data, wr_addr, wdata, rd_addr, rdata, err_addr;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  weight_programmer #(.N(N), .ADDR_MASK(MASK)) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start), .verify_en(verify_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .rd_addr(rd_addr),
    .rdata(rdata), .busy(busy), .done(done), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    return {MASK, 11'(idx / N), 11'(idx % N), 2'b00};
  endfunction

  // Shared between driver and monitor
  int          corrupt_mode = 0;
  logic        force_req = 1'b0;
  int          cyc = 0, hs_count = 0, done_cnt = 0, stall_cnt = 0;
  logic [31:0] wr_addrs[$];
  logic [31:0] wr_datas[$];
  int          wr_cycles[$];

  function automatic logic [31:0] pick_rdata(input int idx, input logic [31:0] v);
    case (corrupt_mode)
      1:       return (idx == 2) ? 32'hDEAD : v;
      2:       return ~v;
      3:       return ($urandom_range(0, 3) == 0) ? (v ^ (32'h1 << $urandom_range(0, 31))) : v;
      default: return v;
    endcase
  endfunction

  // Reference model: pair index walks 0..N*N-1; a word costs 2 cycles (4 with verify)
  logic        model_valid = 1'b0;
  logic        m_busy = 1'b0, m_fetch = 1'b0, m_verify = 1'b0, m_seen = 1'b0;
  int          m_idx = 0, m_timer = 0;
  logic        e_in_ready = 1'b0, e_wready = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic        nx_wready, nx_done;
  logic [31:0] e_wr_addr = '0, e_wdata = '0, e_rd_addr = '0, e_err_addr = '0;
  logic [15:0] e_err = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (model_valid) begin
        chk("in_ready", in_ready, e_in_ready);
        chk("wready", wready, e_wready);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("wr_addr", wr_addr, e_wr_addr);
        chk("wdata", wdata, e_wdata);
        chk("rd_addr", rd_addr, e_rd_addr);
        chk("err_count", err_count, e_err);
        chk("err_addr", err_addr, e_err_addr);
      end
      if (wready) begin
        wr_addrs.push_back(wr_addr);
        wr_datas.push_back(wdata);
        wr_cycles.push_back(cyc);
      end
      if (done) done_cnt++;
      if (busy && in_ready && !in_valid) stall_cnt++;
      if (in_valid && in_ready) hs_count++;
      if (force_req) begin
        force_req = 1'b0;
        force dut.err_count = 16'hFFFD;
        #1 release dut.err_count;
        e_err = 16'hFFFD;
      end
      if (axi_rst) begin
        model_valid = 1'b1;
        m_busy = 1'b0; m_fetch = 1'b0; m_verify = 1'b0; m_seen = 1'b0;
        m_idx = 0; m_timer = 0;
        e_wr_addr = '0; e_wdata = '0; e_rd_addr = '0; e_err = '0; e_err_addr = '0;
        e_wready = 1'b0; e_done = 1'b0;
      end else if (model_valid) begin
        nx_wready = 1'b0;
        nx_done   = 1'b0;
        if (e_done) begin
          m_busy = 1'b0;
        end else if (!m_busy) begin
          if (start) begin
            m_busy = 1'b1; m_verify = verify_en; m_idx = 0; m_fetch = 1'b1;
            e_err = '0; e_err_addr = '0; m_seen = 1'b0;
          end
        end else if (m_fetch) begin
          if (in_valid) begin
            e_wdata = in_data; e_wr_addr = addr_of(m_idx);
            nx_wready = 1'b1; m_fetch = 1'b0;
            m_timer = m_verify ? 3 : 1;
          end
        end else if (m_timer > 0) begin
          m_timer--;
          if (m_verify && m_timer == 2) e_rd_addr = e_wr_addr;
          if (m_verify && m_timer == 1) rdata = pick_rdata(m_idx, e_wdata);
          if (m_timer == 0) begin
            if (m_verify && rdata !== e_wdata) begin
              if (e_err != 16'hFFFF) e_err++;
              if (!m_seen) begin m_seen = 1'b1; e_err_addr = e_wr_addr; end
            end
            if (m_idx == N * N - 1) nx_done = 1'b1;
            else begin m_idx++; m_fetch = 1'b1; end
          end
        end
        e_wready = nx_wready;
        e_done   = nx_done;
      end
      e_in_ready = m_fetch;
      e_busy     = m_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 always valid, 1 random valid/data, 2 five-cycle stall before the third word
  task automatic run_sweep(input logic ver, input int cmode, input int vmode,
                           input int extra_start, input int force_at);
    int gap = 5;
    int t = 0;
    corrupt_mode = cmode;
    wr_addrs.delete(); wr_datas.delete(); wr_cycles.delete();
    done_cnt = 0; stall_cnt = 0; hs_count = 0;
    start = 1'b1; verify_en = ver;
    tick();
    start = 1'b0; verify_en = 1'($urandom);
    while (done_cnt == 0 && t < 300) begin
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = ($urandom_range(0, 3) != 0);
        default: begin
          in_valid = !(hs_count == 2 && gap > 0);
          if (!in_valid && in_ready) gap--;
        end
      endcase
      in_data = (vmode == 1) ? $urandom : 32'(hs_count + 1);
      start = (t == extra_start);
      if (t == force_at) force_req = 1'b1;
      tick();
      t++;
    end
    start = 1'b0;
    chk("sweep_completes", 32'(done_cnt != 0), 32'd1);
  endtask

  logic [31:0] exp_a[4] = '{32'hA5000000, 32'hA5000004, 32'hA5002000, 32'hA5002004};

  initial begin
    int t;
    axi_rst = 1'b1; start = 1'b0; verify_en = 1'b0; in_valid = 1'b0;
    in_data = '0; rdata = '0;
    repeat (3) tick();
    axi_rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_err_count", err_count, 16'h0);
    chk("reset_wr_addr", wr_addr, 32'h0);
    tick();

    // Plain sweep, words 1..4 back to back
    run_sweep(1'b0, 0, 0, -1, -1);
    chk("plain_writes", wr_addrs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("plain_addr", wr_addrs[i], exp_a[i]);
      chk("plain_data", wr_datas[i], 32'(i + 1));
      if (i > 0) chk("plain_cadence", wr_cycles[i] - wr_cycles[i-1], 2);
    end
    chk("plain_done", done_cnt, 1);
    chk("plain_errs", err_count, 16'h0);
    tick();

    // Verify with echoing memory
    run_sweep(1'b1, 0, 0, -1, -1);
    for (int i = 1; i < 4; i++) chk("verify_cadence", wr_cycles[i] - wr_cycles[i-1], 4);
    chk("verify_errs", err_count, 16'h0);
    chk("verify_err_addr", err_addr, 32'h0);
    chk("verify_rd_addr", rd_addr, 32'hA5002004);
    tick();

    // Single corrupted readback at d=1, s=0
    run_sweep(1'b1, 1, 0, -1, -1);
    chk("dead_errs", err_count, 16'h1);
    chk("dead_err_addr", err_addr, 32'hA5002000);
    tick();

    // Stall of five FETCH cycles before the third word
    run_sweep(1'b0, 0, 2, -1, -1);
    chk("gap_stalls", stall_cnt, 5);
    chk("gap_writes", wr_addrs.size(), 4);
    for (int i = 0; i < 4; i++) chk("gap_data", wr_datas[i], 32'(i + 1));
    chk("gap_cadence_long", wr_cycles[2] - wr_cycles[1], 7);
    tick();

    // Reset after the second write aborts the sweep
    wr_addrs.delete(); wr_datas.delete(); wr_cycles.delete(); hs_count = 0;
    corrupt_mode = 0;
    start = 1'b1; verify_en = 1'b0;
    tick();
    start = 1'b0;
    t = 0;
    while (wr_addrs.size() < 2 && t < 50) begin
      in_valid = 1'b1; in_data = 32'(hs_count + 1);
      tick(); t++;
    end
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_wready", wready, 1'b0);
    chk("abort_wdata", wdata, 32'h0);
    chk("abort_wr_addr", wr_addr, 32'h0);
    repeat (4) tick();
    chk("abort_no_more_writes", wr_addrs.size(), 2);
    run_sweep(1'b0, 0, 0, -1, -1);
    chk("restart_addr", wr_addrs[0], 32'hA5000000);
    chk("restart_data", wr_datas[0], 32'h1);
    tick();

    // Near-saturated count, every readback wrong, start pulsed mid-sweep
    run_sweep(1'b1, 2, 0, 5, 1);
    chk("sat_errs", err_count, 16'hFFFF);
    chk("sat_err_addr", err_addr, 32'hA5000000);
    chk("sat_single_sweep", wr_addrs.size(), 4);
    chk("sat_done_once", done_cnt, 1);
    tick();

    // Randomised sweeps
    for (int k = 0; k < 20; k++) begin
      run_sweep(1'($urandom), 3, 1, $urandom_range(0, 12), -1);
      chk("rand_writes", wr_addrs.size(), 4);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_programmer.md
WEIGHT_PROGRAMMER -- requirements
Module: weight_programmer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning spin count; one sweep covers N*N (s,d) pairs.
REQ-002 The block SHALL have parameter ADDR_MASK, default `WEIGHT_ADDR_MASK, meaning the value driven on wr_addr[31:24] and rd_addr[31:24].
REQ-003 The block SHALL have port clk  in  1  meaning single clock; all logic is rising-edge.
REQ-004 The block SHALL have port axi_rst  in  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port start  in  1  meaning single-cycle pulse that begins a sweep.
REQ-006 The block SHALL have port verify_en  in  1  meaning enables readback compare; sampled on the accepted start.
REQ-007 The block SHALL have port in_valid  in  1  meaning weight word available.
REQ-008 The block SHALL have port in_ready  out  1  meaning weight word accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have port in_data  in  32  meaning weight word.
REQ-010 The block SHALL have ports wready out 1, wr_addr out 32, wdata out 32, rd_addr out 32, meaning matrix write/read command bus.
REQ-011 The block SHALL have port rdata  in  32  meaning matrix readback, valid the cycle after rd_addr is driven with wready low.
REQ-012 The block SHALL have ports busy out 1, done out 1, err_count out 16, err_addr out 32, meaning status.

Function
REQ-013 The block SHALL use states IDLE, FETCH, WRITE, READ, CHECK and DONE.
REQ-014 Address encoding SHALL be {ADDR_MASK, d[10:0], s[10:0], 2'b00} for both write and read.
REQ-015 Pair order SHALL be s inner (0..N-1) and d outer (0..N-1), starting at s=0, d=0.
REQ-016 In IDLE, a start pulse SHALL clear err_count and err_addr, latch verify_en, zero s/d, assert busy and go to FETCH.
REQ-017 A start pulse while busy SHALL be ignored.
REQ-018 In FETCH, in_ready SHALL be 1; on handshake, in_data SHALL be latched into wdata and the state SHALL go to WRITE.
REQ-019 in_ready SHALL be 0 in every state other than FETCH.
REQ-020 WRITE SHALL last exactly one cycle with wready=1 and wr_addr set to the encoded current pair.
REQ-021 wready SHALL be 0 in every state other than WRITE.
REQ-022 From WRITE, the state SHALL go to READ if verify is latched, otherwise it SHALL advance the pair.
REQ-023 READ SHALL drive rd_addr with the current pair address for one cycle.
REQ-024 CHECK SHALL compare rdata against wdata; on mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-025 On the first mismatch of a sweep only, err_addr SHALL capture the pair address.
REQ-026 rd_addr SHALL hold the current pair address through READ and CHECK.
REQ-027 Pair advance: if the last pair (s=N-1, d=N-1) is complete, the state SHALL go to DONE; otherwise s SHALL increment, wrapping to 0 with d incrementing, and the state SHALL go to FETCH.
REQ-028 DONE SHALL last one cycle: done=1, busy deasserts next cycle, then return to IDLE.
REQ-029 busy SHALL be 1 from the cycle after an accepted start through DONE inclusive.
REQ-030 err_count and err_addr SHALL hold until the next accepted start.
REQ-031 Throughput SHALL be 2 cycles per pair without verify and 4 cycles per pair with verify, given in_valid continuously high.
REQ-032 An in_valid stall in FETCH SHALL wait indefinitely with no timeout and wready held 0.
REQ-033 wdata SHALL be stable from WRITE through CHECK.

Reset
REQ-034 While axi_rst is high at a clock edge, state SHALL be IDLE and busy, done, wready, in_ready SHALL be 0.
REQ-035 While axi_rst is high at a clock edge, wr_addr, wdata, rd_addr, err_count and err_addr SHALL be 0, and s/d SHALL be 0.
REQ-036 Reset asserted mid-sweep SHALL abort immediately with no further write issued, and a new start is required afterward.

Verification
REQ-037 N=2, verify off, in_data 1,2,3,4 always valid -> 4 wready pulses, 2 cycles apart, at wr_addr[23:2] (d,s) = (0,0),(0,1),(1,0),(1,1); done once; err_count=0.
REQ-038 N=2, verify on, model echoes writes -> 4-cycle cadence; rd_addr equals the prior wr_addr; err_count=0; err_addr=0.
REQ-039 N=2, verify on, model returns 32'hDEAD for pair (1,0) only -> err_count=1; err_addr={ADDR_MASK, 11'd1, 11'd0, 2'b00}.
REQ-040 in_valid low for 5 cycles before the third word -> wready stays 0 and in_ready stays 1 during the gap; sweep completes with correct data order.
REQ-041 axi_rst pulsed after the second write -> all outputs 0 next cycle; a following start reprograms from (0,0).
REQ-042 start pulsed while busy, plus err_count forced near saturation over a long mismatch run -> start ignored; err_count stops at 16'hFFFF.
